// File: rtl/manta_bus_hub_if.sv
// Bus bundle between the manta receiver/transmitter pair, the hub and its cores.
// The hub takes the slave view; the receiver, transmitter and cores sit on the master side.
interface manta_bus_hub_if #(
    parameter int unsigned N_CORES   = 4,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned SPAN_LOG2 = 12
);
    logic [ADDR_W-1:0]         addr_i;
    logic [DATA_W-1:0]         data_i;
    logic                      rw_i;
    logic                      valid_i;
    logic [SPAN_LOG2-1:0]      core_addr_o;
    logic [DATA_W-1:0]         core_data_o;
    logic                      core_rw_o;
    logic [N_CORES-1:0]        core_valid_o;
    logic [N_CORES*DATA_W-1:0] core_data_i;
    logic [N_CORES-1:0]        core_valid_i;
    logic [ADDR_W-1:0]         addr_o;
    logic [DATA_W-1:0]         data_o;
    logic                      valid_o;
    logic                      err_o;
    logic [15:0]               drop_cnt_o;

    modport slave (
        input  addr_i, data_i, rw_i, valid_i, core_data_i, core_valid_i,
        output core_addr_o, core_data_o, core_rw_o, core_valid_o,
               addr_o, data_o, valid_o, err_o, drop_cnt_o
    );

    modport master (
        output addr_i, data_i, rw_i, valid_i, core_data_i, core_valid_i,
        input  core_addr_o, core_data_o, core_rw_o, core_valid_o,
               addr_o, data_o, valid_o, err_o, drop_cnt_o
    );
endinterface

// File: rtl/manta_bus_hub.sv
// Star-topology hub: one request at a time, decoded by upper address bits to one core,
// with read timeout, unmapped-read error response and a saturating drop counter.
module manta_bus_hub #(
    parameter int unsigned       N_CORES   = 4,
    parameter int unsigned       ADDR_W    = 16,
    parameter int unsigned       DATA_W    = 16,
    parameter int unsigned       SPAN_LOG2 = 12,
    parameter int unsigned       TIMEOUT   = 255,
    parameter logic [DATA_W-1:0] ERR_DATA  = 16'hDEAD
) (
    input logic             clk,
    input logic             rst_n,
    manta_bus_hub_if.slave  bus
);
    localparam int unsigned IDX_W = ADDR_W - SPAN_LOG2;
    localparam int unsigned SEL_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 rw_q, rw_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [15:0]          tmo_q, tmo_d;
    logic [SPAN_LOG2-1:0] core_addr_q, core_addr_d;
    logic [DATA_W-1:0]    core_data_q, core_data_d;
    logic                 core_rw_q, core_rw_d;
    logic [N_CORES-1:0]   core_valid_q, core_valid_d;
    logic [ADDR_W-1:0]    addr_o_q, addr_o_d;
    logic [DATA_W-1:0]    data_o_q, data_o_d;
    logic                 valid_o_q, valid_o_d;
    logic                 err_o_q, err_o_d;
    logic [15:0]          drop_q, drop_d;

    logic [IDX_W-1:0]     in_idx;
    logic [SEL_W-1:0]     in_sel;
    logic                 in_mapped;
    logic                 busy;

    assign in_idx    = bus.addr_i[ADDR_W-1:SPAN_LOG2];
    assign in_sel    = in_idx[SEL_W-1:0];
    assign in_mapped = (32'(in_idx) < N_CORES);
    // The IDLE cycle that presents a response still counts as busy for new requests.
    assign busy      = (state_q != S_IDLE) || valid_o_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rw_d         = rw_q;
        sel_d        = sel_q;
        tmo_d        = tmo_q;
        core_addr_d  = core_addr_q;
        core_data_d  = core_data_q;
        core_rw_d    = core_rw_q;
        core_valid_d = '0;
        addr_o_d     = addr_o_q;
        data_o_d     = data_o_q;
        valid_o_d    = 1'b0;
        err_o_d      = 1'b0;
        drop_d       = drop_q;

        if (bus.valid_i && busy && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.valid_i && !valid_o_q) begin
                    addr_d = bus.addr_i;
                    rw_d   = bus.rw_i;
                    sel_d  = in_sel;
                    if (in_mapped) begin
                        state_d              = S_ISSUE;
                        core_valid_d[in_sel] = 1'b1;
                        core_addr_d          = bus.addr_i[SPAN_LOG2-1:0];
                        core_data_d          = bus.data_i;
                        core_rw_d            = bus.rw_i;
                    end else if (!bus.rw_i) begin
                        valid_o_d = 1'b1;
                        err_o_d   = 1'b1;
                        data_o_d  = ERR_DATA;
                        addr_o_d  = bus.addr_i;
                    end
                end
            end
            S_ISSUE: begin
                tmo_d   = '0;
                state_d = rw_q ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (bus.core_valid_i[sel_q]) begin
                    valid_o_d = 1'b1;
                    data_o_d  = bus.core_data_i[sel_q*DATA_W +: DATA_W];
                    addr_o_d  = addr_q;
                    state_d   = S_IDLE;
                end else if (tmo_q == 16'(TIMEOUT - 1)) begin
                    valid_o_d = 1'b1;
                    err_o_d   = 1'b1;
                    data_o_d  = ERR_DATA;
                    addr_o_d  = addr_q;
                    state_d   = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            rw_q         <= 1'b0;
            sel_q        <= '0;
            tmo_q        <= '0;
            core_addr_q  <= '0;
            core_data_q  <= '0;
            core_rw_q    <= 1'b0;
            core_valid_q <= '0;
            addr_o_q     <= '0;
            data_o_q     <= '0;
            valid_o_q    <= 1'b0;
            err_o_q      <= 1'b0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rw_q         <= rw_d;
            sel_q        <= sel_d;
            tmo_q        <= tmo_d;
            core_addr_q  <= core_addr_d;
            core_data_q  <= core_data_d;
            core_rw_q    <= core_rw_d;
            core_valid_q <= core_valid_d;
            addr_o_q     <= addr_o_d;
            data_o_q     <= data_o_d;
            valid_o_q    <= valid_o_d;
            err_o_q      <= err_o_d;
            drop_q       <= drop_d;
        end
    end

    assign bus.core_addr_o  = core_addr_q;
    assign bus.core_data_o  = core_data_q;
    assign bus.core_rw_o    = core_rw_q;
    assign bus.core_valid_o = core_valid_q;
    assign bus.addr_o       = addr_o_q;
    assign bus.data_o       = data_o_q;
    assign bus.valid_o      = valid_o_q;
    assign bus.err_o        = err_o_q;
    assign bus.drop_cnt_o   = drop_q;
endmodule
